// File: rtl/cpu_write_buffer.sv
// cpu_write_buffer: posted-write buffer between a CPU data port and the bus arbiter.
// Writes are acknowledged as soon as they land in a small circular FIFO. A drain FSM
// pushes the FIFO out to the bus. Reads wait until the buffer is empty and the FSM
// is idle, so program order is kept without store-to-load forwarding.
module cpu_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_rw,
    input  logic        i_request,
    output logic        o_ready,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    output logic        o_idle
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RELEASE
    } state_t;

    logic [31:0]      fifo_address [DEPTH];
    logic [31:0]      fifo_wdata   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    state_t state;
    state_t state_next;

    logic        ack_latch;
    logic        armed;
    logic        push;
    logic        pop;
    logic        read_done;

    logic        bus_request_next;
    logic        bus_rw_next;
    logic [31:0] bus_address_next;
    logic [31:0] bus_wdata_next;

    // A request is only live until it has been acknowledged and then seen low once.
    assign armed     = i_request && !ack_latch;
    // Fullness is judged on the registered count, so a pop frees its slot one cycle later.
    assign push      = armed && i_rw && (count < CNT_W'(DEPTH));
    assign pop       = (state == WRITE) && i_bus_ready;
    assign read_done = (state == READ) && i_bus_ready;

    // Occupancy after this cycle's push and/or pop; a simultaneous pair cancels out.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Drain FSM next state and next registered bus outputs; writes win over reads.
    always_comb begin
        state_next       = state;
        bus_request_next = o_bus_request;
        bus_rw_next      = o_bus_rw;
        bus_address_next = o_bus_address;
        bus_wdata_next   = o_bus_wdata;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next       = WRITE;
                    bus_request_next = 1'b1;
                    bus_rw_next      = 1'b1;
                    bus_address_next = fifo_address[head];
                    bus_wdata_next   = fifo_wdata[head];
                end else if (armed && !i_rw) begin
                    state_next       = READ;
                    bus_request_next = 1'b1;
                    bus_rw_next      = 1'b0;
                    bus_address_next = i_address;
                    bus_wdata_next   = 32'd0;
                end else begin
                    bus_request_next = 1'b0;
                end
            end
            WRITE: begin
                if (i_bus_ready) begin
                    state_next       = RELEASE;
                    bus_request_next = 1'b0;
                end
            end
            READ: begin
                if (i_bus_ready) begin
                    state_next       = RELEASE;
                    bus_request_next = 1'b0;
                end
            end
            RELEASE: begin
                state_next       = IDLE;
                bus_request_next = 1'b0;
            end
            default: begin
                state_next       = IDLE;
                bus_request_next = 1'b0;
            end
        endcase
    end

    // Drain FSM state register, registered bus outputs and the idle flag.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state         <= IDLE;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= 32'd0;
            o_bus_wdata   <= 32'd0;
            o_idle        <= 1'b1;
        end else begin
            state         <= state_next;
            o_bus_request <= bus_request_next;
            o_bus_rw      <= bus_rw_next;
            o_bus_address <= bus_address_next;
            o_bus_wdata   <= bus_wdata_next;
            o_idle        <= (count_next == '0) && (state_next == IDLE);
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    // FIFO storage; contents are qualified by count so they need no reset.
    always_ff @(posedge i_clock) begin
        if (push) begin
            fifo_address[tail] <= i_address;
            fifo_wdata[tail]   <= i_wdata;
        end
    end

    // Upstream handshake: one-cycle ready pulse, read data capture and acknowledge latch.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_ready   <= 1'b0;
            o_rdata   <= 32'd0;
            ack_latch <= 1'b0;
        end else begin
            o_ready <= push || read_done;
            if (read_done) begin
                o_rdata <= i_bus_rdata;
            end
            if (!i_request) begin
                ack_latch <= 1'b0;
            end else if (push || read_done) begin
                ack_latch <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_write_buffer.sv
// tb_cpu_write_buffer: directed bench for the posted-write buffer. A CPU driver task
// issues transactions, a bus slave is modelled by a ready level and constant read
// data, and a program-order queue of writes predicts every bus transaction.
module tb_cpu_write_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] READ_DATA = 32'h12345678;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rw;
    logic        request;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    logic        o_ready;
    logic [31:0] o_rdata;
    logic        o_bus_rw;
    logic        o_bus_request;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic        o_idle;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] exp_read_addr = 32'd0;
    bit          cpu_waiting   = 1'b0;
    int          writes_seen   = 0;

    bit          prev_valid = 1'b0;
    logic        prev_ready;
    logic        prev_rw;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;

    cpu_write_buffer #(.DEPTH(DEPTH)) dut (
        .i_clock       (clock),
        .i_reset       (reset_n),
        .i_rw          (rw),
        .i_request     (request),
        .o_ready       (o_ready),
        .i_address     (address),
        .i_wdata       (wdata),
        .o_rdata       (o_rdata),
        .o_bus_rw      (o_bus_rw),
        .o_bus_request (o_bus_request),
        .i_bus_ready   (bus_ready),
        .o_bus_address (o_bus_address),
        .i_bus_rdata   (bus_rdata),
        .o_bus_wdata   (o_bus_wdata),
        .o_idle        (o_idle)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // One CPU transaction: raise request, wait for ready (bounded), optionally keep
    // request high for `hold` extra cycles, then drop it. Latency counts negedges from
    // the raise, so an immediately accepted write reports 2.
    task automatic applyStimulus(input bit is_write, input logic [31:0] addr, input logic [31:0] data,
                                 input int hold, output int latency, output logic [31:0] rdata);
        wr_t e;
        bit  got;
        @(posedge clock);
        #1;
        rw          = is_write;
        address     = addr;
        wdata       = data;
        request     = 1'b1;
        cpu_waiting = 1'b1;
        if (is_write) begin
            e.addr = addr;
            e.data = data;
            exp_q.push_back(e);
        end else begin
            exp_read_addr = addr;
        end
        latency = 0;
        got     = 1'b0;
        while (!got && latency < 200) begin
            @(negedge clock);
            latency++;
            if (o_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL ack_timeout addr=0x%08h actual=no ready required=ready within 200 cycles", addr);
        end
        rdata = o_rdata;
        @(posedge clock);
        #1;
        cpu_waiting = 1'b0;
        repeat (hold) @(posedge clock);
        #1;
        request = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        @(negedge clock);
        while (!o_idle && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, {31'd0, o_idle}, 32'd1);
        checkOutput({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"},   {31'd0, o_ready}, 32'd0);
        checkOutput({tag, "_rdata"},   o_rdata, 32'd0);
        checkOutput({tag, "_bus_req"}, {31'd0, o_bus_request}, 32'd0);
        checkOutput({tag, "_bus_rw"},  {31'd0, o_bus_rw}, 32'd0);
        checkOutput({tag, "_bus_addr"}, o_bus_address, 32'd0);
        checkOutput({tag, "_bus_wdata"}, o_bus_wdata, 32'd0);
        checkOutput({tag, "_idle"},    {31'd0, o_idle}, 32'd1);
    endtask

    // Per-cycle compare against the order model and the bus/handshake rules.
    always @(negedge clock) begin
        wr_t e;
        if (reset_n) begin
            if (o_bus_request && bus_ready) begin
                if (o_bus_rw) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_bus_write actual addr=0x%08h data=0x%08h required=no bus write",
                                 o_bus_address, o_bus_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("bus_write_addr", o_bus_address, e.addr);
                        checkOutput("bus_write_data", o_bus_wdata, e.data);
                        writes_seen++;
                    end
                end else begin
                    checkOutput("read_after_drain", 32'(exp_q.size()), 32'd0);
                    checkOutput("bus_read_addr", o_bus_address, exp_read_addr);
                end
            end
            if (o_bus_request && !o_bus_rw) begin
                checkOutput("bus_read_wdata_zero", o_bus_wdata, 32'd0);
            end
            if (prev_valid && !prev_ready && o_bus_request) begin
                checkOutput("bus_stable_rw", {31'd0, o_bus_rw}, {31'd0, prev_rw});
                checkOutput("bus_stable_addr", o_bus_address, prev_addr);
                checkOutput("bus_stable_wdata", o_bus_wdata, prev_wdata);
            end
            if (o_ready && !cpu_waiting) begin
                checks++;
                failures++;
                $display("[TB] FAIL spurious_ready actual=1 required=0");
            end
            prev_valid <= o_bus_request;
            prev_ready <= bus_ready;
            prev_rw    <= o_bus_rw;
            prev_addr  <= o_bus_address;
            prev_wdata <= o_bus_wdata;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        int          seen_before;
        int          req_cycles;

        reset_n   = 1'b0;
        rw        = 1'b0;
        request   = 1'b0;
        address   = 32'd0;
        wdata     = 32'd0;
        bus_ready = 1'b0;
        bus_rdata = READ_DATA;

        // Power-on reset, then check every output the cycle after release.
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        checkResetOutputs("por");

        // Single write with the bus always ready.
        bus_ready = 1'b1;
        applyStimulus(1'b1, 32'h20000000, 32'hDEADBEEF, 0, lat, rd);
        checkOutput("single_write_latency", 32'(lat), 32'd2);
        waitIdle("single_write_idle");
        checkOutput("single_write_seen", 32'(writes_seen), 32'd1);

        // Five writes into a four-deep buffer with the bus stalled.
        @(posedge clock);
        #1;
        bus_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h30000000 + 32'(i * 4), 32'hA0000000 + 32'(i), 0, lat, rd);
            checkOutput("fill_latency", 32'(lat), 32'd2);
        end
        @(negedge clock);
        checkOutput("full_not_idle", {31'd0, o_idle}, 32'd0);
        fork
            applyStimulus(1'b1, 32'h30000010, 32'hA0000004, 0, lat, rd);
            begin
                repeat (6) @(posedge clock);
                #1;
                bus_ready = 1'b1;
            end
        join
        checkOutput("stalled_write_latency", 32'(lat), 32'd8);
        waitIdle("burst_idle");
        checkOutput("burst_seen", 32'(writes_seen), 32'd6);

        // Two writes then a read that must wait for both to reach the bus.
        @(posedge clock);
        #1;
        bus_ready = 1'b0;
        applyStimulus(1'b1, 32'h20000000, 32'h11111111, 0, lat, rd);
        applyStimulus(1'b1, 32'h20000008, 32'h22222222, 0, lat, rd);
        fork
            applyStimulus(1'b0, 32'h20000004, 32'd0, 0, lat, rd);
            begin
                repeat (5) @(posedge clock);
                #1;
                bus_ready = 1'b1;
            end
        join
        checkOutput("read_latency", 32'(lat), 32'd12);
        checkOutput("read_data", rd, READ_DATA);
        waitIdle("read_idle");

        // Request held high after ready: exactly one acceptance, then normal again.
        applyStimulus(1'b1, 32'h40000000, 32'h0000CAFE, 4, lat, rd);
        checkOutput("held_first_latency", 32'(lat), 32'd2);
        applyStimulus(1'b1, 32'h40000004, 32'h0000BABE, 0, lat, rd);
        checkOutput("after_drop_latency", 32'(lat), 32'd2);
        waitIdle("held_idle");
        checkOutput("held_seen", 32'(writes_seen), 32'd10);

        // Fill, then stream writes while draining so pushes and pops overlap across wrap.
        @(posedge clock);
        #1;
        bus_ready   = 1'b0;
        seen_before = writes_seen;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h50000000 + 32'(i * 4), 32'hB0000000 + 32'(i), 0, lat, rd);
        end
        @(posedge clock);
        #1;
        bus_ready = 1'b1;
        for (int i = DEPTH; i < DEPTH + 6; i++) begin
            applyStimulus(1'b1, 32'h50000000 + 32'(i * 4), 32'hB0000000 + 32'(i), 0, lat, rd);
        end
        waitIdle("wrap_idle");
        checkOutput("wrap_seen", 32'(writes_seen - seen_before), 32'(DEPTH + 6));

        // Reset with three writes buffered and a bus write in progress.
        @(posedge clock);
        #1;
        bus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h60000000 + 32'(i * 4), 32'hC0000000 + 32'(i), 0, lat, rd);
        end
        @(negedge clock);
        checkOutput("pre_reset_bus_req", {31'd0, o_bus_request}, 32'd1);
        checkOutput("pre_reset_bus_addr", o_bus_address, 32'h60000000);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset_drops_bus_req", {31'd0, o_bus_request}, 32'd0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        bus_ready = 1'b1;
        @(negedge clock);
        checkResetOutputs("mid_reset");
        req_cycles = 0;
        repeat (12) begin
            @(negedge clock);
            if (o_bus_request) req_cycles++;
        end
        checkOutput("no_stale_writes", 32'(req_cycles), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
